// File: rtl/rng_arbiter.sv
// Three-way round-robin arbiter that hands out 5-bit random values from a
// 16-bit Fibonacci LFSR, then enforces a fixed HOLD gap after every grant.
module rng_arbiter #(
    parameter logic [15:0] SEED = 16'd27581,
    parameter int unsigned GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic [2:0]  rd_valid,
    output logic [4:0]  rd_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t      state, state_n;
    logic [15:0] lfsr, lfsr_n;
    logic [1:0]  last, last_n;
    logic [3:0]  cnt, cnt_n;
    logic [2:0]  rd_valid_n;
    logic [4:0]  rd_data_n;
    logic        busy_n;
    logic [1:0]  winner, idx;
    logic        found;

    // A zero seed would lock the LFSR, so it is replaced by SEED.
    always_comb begin
        if (seed_load)
            lfsr_n = (seed_in == '0) ? SEED : seed_in;
        else
            lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[12] ^ lfsr[4]};
    end

    // Search starts one past the previous winner and wraps modulo 3.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = (last == 2'd2) ? 2'd0 : last + 2'd1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_n     = last;
        rd_valid_n = '0;
        rd_data_n  = rd_data;
        busy_n     = busy;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (found) begin
                    state_n    = GRANT;
                    last_n     = winner;
                    rd_data_n  = lfsr[15:11];
                    rd_valid_n = 3'(3'b001 << winner);
                    busy_n     = 1'b1;
                end
            end
            GRANT: begin
                state_n = HOLD;
                cnt_n   = 4'(GAP - 1);
                busy_n  = 1'b1;
            end
            HOLD: begin
                busy_n = 1'b1;
                if (cnt == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= SEED;
            state    <= IDLE;
            last     <= 2'd2;
            cnt      <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
        end else begin
            lfsr     <= lfsr_n;
            state    <= state_n;
            last     <= last_n;
            cnt      <= cnt_n;
            rd_valid <= rd_valid_n;
            rd_data  <= rd_data_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter: expected grants are queued as stimulus is
// driven and matched against every rd_valid pulse on the falling edge.
module tb_rng_arbiter;

    localparam logic [15:0] SEED = 16'h6BBD;
    localparam int unsigned GAP  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [2:0]  rd_valid;
    logic [4:0]  rd_data;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [2:0] v;
        logic [4:0] d;
    } exp_t;
    exp_t q[$];

    logic [15:0] m_lfsr;

    rng_arbiter #(.SEED(SEED), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference LFSR driven only by the bench's own inputs.
    always @(posedge clk) begin
        if (reset)
            m_lfsr <= SEED;
        else if (seed_load)
            m_lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
        else
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[12] ^ m_lfsr[4]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] v, input logic [4:0] d);
        exp_t e;
        e.v = v;
        e.d = d;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rd_valid !== 3'b000) begin
            check("onehot", 32'($onehot(rd_valid)), 32'd1);
            if (q.size() == 0) begin
                check("unexpected_grant", 32'(rd_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("grant_valid", 32'(rd_valid), 32'(e.v));
                check("grant_data", 32'(rd_data), 32'(e.d));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait();
        repeat (GAP + 1) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [2:0] oh(input int unsigned k);
        logic [2:0] one;
        one = 3'b001;
        return 3'(one << k);
    endfunction

    initial begin
        reset     = 1'b1;
        req       = 3'b000;
        seed_load = 1'b0;
        seed_in   = 16'h0000;
        step();
        step();
        reset = 1'b0;

        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr), 32'h6BBD);

        // Seeded grant with known data.
        seed_load = 1'b1;
        seed_in   = 16'h6BBD;
        step();
        seed_load = 1'b0;
        req       = 3'b001;
        push(3'b001, 5'h0D);
        step();
        check("seed_lfsr", 32'(dut.lfsr), 32'hD77B);
        check("grant_busy", 32'(busy), 32'd1);
        req = 3'b000;
        idle_wait();
        check("idle_busy", 32'(busy), 32'd0);

        // Round-robin pointer wrap: 0 -> 1 -> 0.
        req = 3'b011;
        push(3'b010, m_lfsr[15:11]);
        step();
        req = 3'b000;
        idle_wait();
        req = 3'b001;
        push(3'b001, m_lfsr[15:11]);
        step();
        req = 3'b000;
        idle_wait();

        // Request raised only while busy is never served.
        req = 3'b010;
        push(3'b010, m_lfsr[15:11]);
        step();
        req = 3'b100;
        idle_wait();
        req = 3'b000;
        repeat (3) step();
        check("hold_req_busy", 32'(busy), 32'd0);

        // Request withdrawn before the sampling edge.
        req = 3'b001;
        #2;
        req = 3'b000;
        step();
        check("withdrawn_busy", 32'(busy), 32'd0);

        // Seed load coincident with a grant uses the pre-load value.
        req       = 3'b100;
        seed_load = 1'b1;
        seed_in   = 16'h1234;
        push(3'b100, m_lfsr[15:11]);
        step();
        req       = 3'b000;
        seed_load = 1'b0;
        check("coincident_lfsr", 32'(dut.lfsr), 32'h1234);
        idle_wait();
        req = 3'b011;
        push(3'b001, m_lfsr[15:11]);
        step();
        req = 3'b000;
        idle_wait();

        // All requesters held: fixed rotation and spacing.
        do_reset();
        req = 3'b111;
        for (int unsigned i = 0, k = 0; i < 30; i++) begin
            int unsigned ph;
            ph = i % (GAP + 2);
            if (ph == 0) begin
                push(oh(k % 3), m_lfsr[15:11]);
                k++;
            end
            step();
            check("rr_pulse", 32'(rd_valid != 3'b000), 32'(ph == 0));
            check("rr_busy", 32'(busy), 32'(ph != GAP + 1));
        end
        req = 3'b000;
        step();

        // Reset during HOLD aborts the cycle.
        req = 3'b001;
        push(3'b001, m_lfsr[15:11]);
        step();
        req = 3'b000;
        step();
        step();
        check("hold_cnt", 32'(dut.cnt), 32'd2);
        do_reset();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(rd_valid), 32'd0);
        check("abort_lfsr", 32'(dut.lfsr), 32'h6BBD);
        req = 3'b110;
        push(3'b010, m_lfsr[15:11]);
        step();
        req = 3'b000;
        idle_wait();

        // Zero seed is substituted; long run never reaches zero.
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        step();
        seed_load = 1'b0;
        check("zero_seed", 32'(dut.lfsr), 32'h6BBD);
        for (int unsigned i = 0; i < 1000; i++) begin
            step();
            check("lfsr_track", 32'(dut.lfsr), 32'(m_lfsr));
            check("lfsr_nonzero", 32'(dut.lfsr != 16'h0000), 32'd1);
        end

        step();
        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
